// File: rtl/cpu_sequencer_if.sv
// Control/strobe bundle between the lab5 sequencer and the datapath.
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run_en;
    logic             step;
    logic [6:0]       opcode;
    logic             ir_load;
    logic             pc_we;
    logic             rf_we;
    logic             ram_rden;
    logic             ram_wren;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        output run_en, step, opcode,
        input  ir_load, pc_we, rf_we, ram_rden, ram_wren, halted, state, retired
    );

    modport slave (
        input  run_en, step, opcode,
        output ir_load, pc_we, rf_we, ram_rden, ram_wren, halted, state, retired
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the lab5 RISC-V datapath.
// All datapath write strobes are a pure decode of state and the latched opcode class.
//
//   state    | meaning
//   IDLE     | waiting for run_en or a step edge
//   FETCH    | ROM addressed with PC, q valid next cycle
//   DECODE   | ir_load, opcode class latched
//   EXEC     | ALU / branch evaluation
//   MEM      | store write or first load read cycle
//   MEM_WAIT | second load read cycle (registered RAM output)
//   WB       | pc_we, rf_we for writing classes; instruction retires
//   HALT     | illegal opcode seen, left only by rst
module cpu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic           CLOCK_50,
    input  logic           rst,
    cpu_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        MEM      = 3'd4,
        MEM_WAIT = 3'd5,
        WB       = 3'd6,
        HALT     = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE = 3'd0,
        CL_R    = 3'd1,
        CL_I    = 3'd2,
        CL_S    = 3'd3,
        CL_L    = 3'd4,
        CL_B    = 3'd5,
        CL_JAL  = 3'd6,
        CL_JALR = 3'd7
    } class_t;

    state_t           state_q, state_d;
    class_t           class_q, class_d;
    class_t           op_class;
    logic             step_q;
    logic             step_pulse;
    logic [CNT_W-1:0] retired_q;

    assign step_pulse = bus.step & ~step_q;

    always_comb begin
        case (bus.opcode)
            7'b0110011: op_class = CL_R;
            7'b0010011: op_class = CL_I;
            7'b0100011: op_class = CL_S;
            7'b0000011: op_class = CL_L;
            7'b1100011: op_class = CL_B;
            7'b1101111: op_class = CL_JAL;
            7'b1100111: op_class = CL_JALR;
            default:    op_class = CL_NONE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            class_q   <= CL_NONE;
            step_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            step_q  <= bus.step;
            if (state_q == WB)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        bus.ir_load  = 1'b0;
        bus.pc_we    = 1'b0;
        bus.rf_we    = 1'b0;
        bus.ram_rden = 1'b0;
        bus.ram_wren = 1'b0;
        case (state_q)
            IDLE: begin
                // step_pulse is only honoured here, so edges elsewhere are dropped
                if (bus.run_en || step_pulse)
                    state_d = FETCH;
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                bus.ir_load = 1'b1;
                class_d     = op_class;
                state_d     = (op_class == CL_NONE) ? HALT : EXEC;
            end
            EXEC: begin
                if (class_q == CL_L || class_q == CL_S)
                    state_d = MEM;
                else
                    state_d = WB;
            end
            MEM: begin
                bus.ram_wren = (class_q == CL_S);
                bus.ram_rden = (class_q == CL_L);
                state_d      = (class_q == CL_L) ? MEM_WAIT : WB;
            end
            MEM_WAIT: begin
                bus.ram_rden = 1'b1;
                state_d      = WB;
            end
            WB: begin
                bus.pc_we = 1'b1;
                bus.rf_we = (class_q != CL_S) && (class_q != CL_B) && (class_q != CL_NONE);
                state_d   = bus.run_en ? FETCH : IDLE;
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign bus.halted  = (state_q == HALT);
    assign bus.state   = state_q;
    assign bus.retired = retired_q;

endmodule
